// File: rtl/rasterizer_depth_fetch_pipe.sv
// Rasterizer depth-fetch stage: colour interpolation, pipelined depth reads,
// credit-limited result queue and drain-accurate done signalling.
module rasterizer_depth_fetch_pipe #(
  parameter int ADDR_W          = 26,
  parameter int DATA_W          = 32,
  parameter int CH_W            = 8,
  parameter int NUM_CH          = 3,
  parameter int FRAC            = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEPTH_OFS       = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        master_address,
  output logic                     master_read,
  output logic                     master_write,
  output logic [DATA_W/8-1:0]      master_byteenable,
  output logic [DATA_W-1:0]        master_writedata,
  input  logic [DATA_W-1:0]        master_readdata,
  input  logic                     master_readdatavalid,
  input  logic                     master_waitrequest,
  input  logic                     input_valid,
  output logic                     stall_out,
  input  logic                     done_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [NUM_CH*CH_W-1:0]   color_in_1,
  input  logic [NUM_CH*CH_W-1:0]   color_in_2,
  input  logic [NUM_CH*CH_W-1:0]   color_in_3,
  input  logic [31:0]              w1,
  input  logic [31:0]              w2,
  input  logic [31:0]              w3,
  input  logic [DATA_W-1:0]        depth_in,
  input  logic                     stall_in,
  output logic                     output_valid,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [DATA_W-1:0]        old_depth_out,
  output logic [DATA_W-1:0]        new_depth_out,
  output logic [NUM_CH*CH_W-1:0]   color_out,
  output logic                     done_out
);

  localparam int CW  = NUM_CH * CH_W;
  localparam int PW  = 32 + CH_W + 1;
  localparam int SW  = 32 + CH_W + 3;
  localparam int PTR = $clog2(MAX_OUTSTANDING);
  localparam int CNT = PTR + 1;
  localparam int MW  = ADDR_W + CW + DATA_W;
  localparam int RW  = MW + DATA_W;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t state_q, state_d;

  logic                 run_q, flush_q;
  logic                 a_valid;
  logic signed [PW-1:0] a_prod [3][NUM_CH];
  logic [ADDR_W-1:0]    a_addr;
  logic [DATA_W-1:0]    a_depth;
  logic [CW-1:0]        a_color;
  logic [CNT-1:0]       credits;
  logic                 can_issue, issue, a_take;
  logic                 rd_push, res_pop, fire, done_pending;

  logic [MW-1:0]        m_mem [MAX_OUTSTANDING];
  logic [RW-1:0]        r_mem [MAX_OUTSTANDING];
  logic [PTR-1:0]       m_wp, m_rp, r_wp, r_rp;
  logic [CNT-1:0]       m_cnt, r_cnt;

  assign master_write      = 1'b0;
  assign master_byteenable = '1;
  assign master_writedata  = '0;

  function automatic logic [CH_W-1:0] sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] lim;
    lim = SW'({CH_W{1'b1}}) << FRAC;
    if (s < 0)         sat = '0;
    else if (s >= lim) sat = '1;
    else               sat = s[FRAC+:CH_W];
  endfunction

  always_comb begin
    a_color = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      a_color[k*CH_W+:CH_W] = sat(SW'(a_prod[0][k]) +
                                  SW'(a_prod[1][k]) +
                                  SW'(a_prod[2][k]));
    end
  end

  assign can_issue = a_valid && (credits < CNT'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          issue   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!master_waitrequest) begin
          if (can_issue) issue   = 1'b1;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage A frees up in the same cycle its fragment issues.
  assign stall_out = !run_q || (a_valid && !issue);
  assign a_take    = input_valid && !stall_out;

  // Reads issued before reset may still return; they are dropped until the
  // first post-reset issue.
  assign rd_push   = master_readdatavalid && !flush_q && (m_cnt != '0);
  assign res_pop   = (r_cnt != '0) && !stall_in;
  assign fire      = done_pending && !a_valid &&
                     (state_q == S_IDLE) && (credits == '0);

  assign output_valid = (r_cnt != '0);
  assign {addr_out, color_out, new_depth_out, old_depth_out} = r_mem[r_rp];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      run_q          <= 1'b0;
      flush_q        <= 1'b1;
      a_valid        <= 1'b0;
      master_read    <= 1'b0;
      master_address <= '0;
      credits        <= '0;
      m_wp           <= '0;
      m_rp           <= '0;
      m_cnt          <= '0;
      r_wp           <= '0;
      r_rp           <= '0;
      r_cnt          <= '0;
      done_pending   <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      master_read <= (state_d == S_REQ);
      if (issue) begin
        master_address <= a_addr + ADDR_W'(DEPTH_OFS);
        flush_q        <= 1'b0;
      end
      if (a_take)     a_valid <= 1'b1;
      else if (issue) a_valid <= 1'b0;
      credits <= credits + CNT'(issue) - CNT'(res_pop);
      if (issue)   m_wp <= m_wp + 1'b1;
      if (rd_push) m_rp <= m_rp + 1'b1;
      m_cnt <= m_cnt + CNT'(issue) - CNT'(rd_push);
      if (rd_push) r_wp <= r_wp + 1'b1;
      if (res_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CNT'(rd_push) - CNT'(res_pop);
      done_out     <= fire;
      done_pending <= done_in || (done_pending && !fire);
    end
  end

  always_ff @(posedge clock) begin
    if (a_take) begin
      a_addr  <= addr_in;
      a_depth <= depth_in;
      for (int k = 0; k < NUM_CH; k++) begin
        a_prod[0][k] <= PW'($signed(w1)) *
                        PW'($signed({1'b0, color_in_1[k*CH_W+:CH_W]}));
        a_prod[1][k] <= PW'($signed(w2)) *
                        PW'($signed({1'b0, color_in_2[k*CH_W+:CH_W]}));
        a_prod[2][k] <= PW'($signed(w3)) *
                        PW'($signed({1'b0, color_in_3[k*CH_W+:CH_W]}));
      end
    end
    if (issue)   m_mem[m_wp] <= {a_addr, a_color, a_depth};
    if (rd_push) r_mem[r_wp] <= {m_mem[m_rp], master_readdata};
  end

  a_rdv_has_meta: assert property (@(posedge clock) disable iff (!reset)
    (master_readdatavalid && !flush_q) |-> (m_cnt != '0));

endmodule

// File: tb/tb_rasterizer_depth_fetch_pipe.sv
// Bench for rasterizer_depth_fetch_pipe: slave with latency/waitrequest,
// arithmetic colour/depth model and in-order scoreboard.
module tb_rasterizer_depth_fetch_pipe;
  localparam int AW = 26;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [AW-1:0] master_address;
  logic          master_read, master_write;
  logic [3:0]    master_byteenable;
  logic [31:0]   master_writedata;
  logic [31:0]   master_readdata = '0;
  logic          master_readdatavalid = 1'b0;
  logic          master_waitrequest = 1'b0;
  logic          input_valid = 1'b0;
  logic          stall_out;
  logic          done_in = 1'b0;
  logic          stall_in = 1'b0;
  logic          output_valid, done_out;
  logic [AW-1:0] addr_out;
  logic [31:0]   old_depth_out, new_depth_out;
  logic [23:0]   color_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   c1, c2, c3;
    logic [31:0]   w1, w2, w3;
    logic [31:0]   depth;
  } frag_t;
  typedef logic [AW+88-1:0] res_t;
  typedef struct { int due; logic [31:0] data; } rd_t;

  frag_t cur;
  res_t  expq[$];
  rd_t   rq[$];
  res_t  last_res;
  int unsigned mem [int unsigned];

  int checks = 0, failures = 0;
  int cyc = 0, n_pops = 0, done_cnt = 0, done_pops = 0;
  int viol = 0, max_q = 0, n_acc_rd = 0;
  logic wr_rand = 1'b0, accepted = 1'b0, prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  rasterizer_depth_fetch_pipe dut (
    .clock(clock), .reset(reset),
    .master_address(master_address), .master_read(master_read),
    .master_write(master_write), .master_byteenable(master_byteenable),
    .master_writedata(master_writedata), .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .input_valid(input_valid), .stall_out(stall_out), .done_in(done_in),
    .addr_in(cur.addr), .color_in_1(cur.c1), .color_in_2(cur.c2),
    .color_in_3(cur.c3), .w1(cur.w1), .w2(cur.w2), .w3(cur.w3),
    .depth_in(cur.depth), .stall_in(stall_in), .output_valid(output_valid),
    .addr_out(addr_out), .old_depth_out(old_depth_out),
    .new_depth_out(new_depth_out), .color_out(color_out),
    .done_out(done_out)
  );

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdmem(logic [AW-1:0] a);
    int unsigned k = a;
    return mem.exists(k) ? mem[k] : (k * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [23:0] model_color(frag_t f);
    logic [23:0] r;
    longint s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = longint'($signed(f.w1)) * longint'(f.c1[k*8+:8]) +
          longint'($signed(f.w2)) * longint'(f.c2[k*8+:8]) +
          longint'($signed(f.w3)) * longint'(f.c3[k*8+:8]);
      if (s < 0)                          r[k*8+:8] = 8'h00;
      else if (s >= (longint'(255) << 16)) r[k*8+:8] = 8'hFF;
      else                                 r[k*8+:8] = 8'(s / 65536);
    end
    return r;
  endfunction

  function automatic res_t model(frag_t f);
    return {f.addr, model_color(f), f.depth, rdmem(f.addr + AW'(4))};
  endfunction

  function automatic frag_t rnd();
    frag_t f;
    f.addr  = AW'($urandom);
    f.c1    = 24'($urandom);
    f.c2    = 24'($urandom);
    f.c3    = 24'($urandom);
    f.w1    = $urandom_range(0, 32'h14000) - 32'h2000;
    f.w2    = $urandom_range(0, 32'h14000) - 32'h2000;
    f.w3    = $urandom_range(0, 32'h14000) - 32'h2000;
    f.depth = $urandom;
    return f;
  endfunction

  // Slave, acceptance tracking and result scoreboard, mid-cycle.
  always @(negedge clock) begin
    res_t got, exp;
    cyc++;
    if (prev_hold && !(master_read && master_address == prev_addr)) viol++;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      master_readdatavalid = 1'b1;
      master_readdata      = rq[0].data;
      void'(rq.pop_front());
    end else begin
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
    end
    master_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (reset && master_read && !master_waitrequest) begin
      rq.push_back('{cyc + 5, rdmem(master_address)});
      n_acc_rd++;
    end
    if (rq.size() > max_q) max_q = rq.size();
    prev_hold = reset && master_read && master_waitrequest;
    prev_addr = master_address;
    #1;
    accepted = input_valid && !stall_out;
    if (accepted) expq.push_back(model(cur));
    if (done_out) begin
      done_cnt++;
      done_pops = n_pops;
    end
    if (output_valid && !stall_in) begin
      n_pops++;
      got = {addr_out, color_out, new_depth_out, old_depth_out};
      last_res = got;
      exp = (expq.size() != 0) ? expq.pop_front() : 'x;
      chk("result", got, exp);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(frag_t f);
    int b = 0;
    cur = f;
    input_valid = 1'b1;
    do begin
      tick();
      b++;
    end while (!accepted && b < 300);
    if (!accepted) chk("send_timeout", accepted, 1'b1);
    input_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((expq.size() != 0 || output_valid) && b < 3000) begin
      tick();
      b++;
    end
    chk("drain", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    frag_t f;
    int p0, n0, d0, nacc;
    cur = rnd();
    #2 reset = 1'b0;
    repeat (3) tick();
    chk("rst_read", master_read, 1'b0);
    chk("rst_addr", master_address, '0);
    chk("rst_ovalid", output_valid, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_stall", stall_out, 1'b1);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_stall", stall_out, 1'b0);

    // single fragment, unit weight on vertex 1
    mem[32'h104] = 32'h0000ABCD;
    f = rnd();
    f.addr = 'h100; f.c1 = 24'h112233;
    f.w1 = 32'h10000; f.w2 = 0; f.w3 = 0; f.depth = 32'h1234;
    n0 = n_acc_rd;
    send(f);
    chk("lat_edgeN", master_read, 1'b0);
    tick();
    chk("lat_edgeN1", master_read, 1'b1);
    chk("t1_addr", master_address, 26'h104);
    drain();
    chk("t1_nreads", n_acc_rd - n0, 1);
    chk("t1_color", last_res[87:64], 24'h112233);
    chk("t1_old", last_res[31:0], 32'h0000ABCD);

    // saturation high and low
    f.c1 = 24'hC0C0C0; f.c2 = 24'hC0C0C0;
    f.w1 = 32'h10000; f.w2 = 32'h10000; f.w3 = 0;
    send(f);
    drain();
    chk("t2_sat_hi", last_res[87:64], 24'hFFFFFF);
    f.w1 = 32'hFFFF0000; f.w2 = 0;
    send(f);
    drain();
    chk("t2_sat_lo", last_res[87:64], 24'h000000);

    // 16 back-to-back fragments, random waitrequest
    wr_rand = 1'b1; max_q = 0; viol = 0; p0 = n_pops;
    for (int i = 0; i < 16; i++) send(rnd());
    drain();
    wr_rand = 1'b0;
    chk("t3_count", n_pops - p0, 16);
    chk("t3_stable", viol, 0);
    chk("t3_outstanding_le8", max_q <= 8, 1'b1);

    // downstream stall with continuous input
    stall_in = 1'b1; p0 = n_pops; nacc = 0;
    cur = rnd(); input_valid = 1'b1;
    repeat (50) begin
      tick();
      if (accepted) begin nacc++; cur = rnd(); end
    end
    chk("t4_accepted", nacc, 9);
    chk("t4_stall_out", stall_out, 1'b1);
    chk("t4_ovalid", output_valid, 1'b1);
    chk("t4_no_pop", n_pops - p0, 0);
    chk("t4_head", {addr_out, color_out, new_depth_out, old_depth_out},
        expq[0]);
    stall_in = 1'b0;
    repeat (20) begin
      tick();
      if (accepted) begin nacc++; cur = rnd(); end
    end
    input_valid = 1'b0;
    drain();
    chk("t4_all", n_pops - p0, nacc);

    // done after three fragments
    stall_in = 1'b1; p0 = n_pops; d0 = done_cnt;
    for (int i = 0; i < 3; i++) send(rnd());
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    repeat (20) tick();
    chk("t5_no_early_done", done_cnt - d0, 0);
    stall_in = 1'b0;
    repeat (30) tick();
    chk("t5_one_pulse", done_cnt - d0, 1);
    chk("t5_after_pops", done_pops - p0, 3);

    // reset with reads in flight
    for (int i = 0; i < 4; i++) send(rnd());
    tick();
    reset = 1'b0;
    #1;
    chk("t6_read", master_read, 1'b0);
    chk("t6_addr", master_address, '0);
    chk("t6_ovalid", output_valid, 1'b0);
    chk("t6_done", done_out, 1'b0);
    chk("t6_stall", stall_out, 1'b1);
    expq.delete();
    tick();
    tick();
    reset = 1'b1;
    repeat (15) tick();
    chk("t6_no_stale", output_valid, 1'b0);
    p0 = n_pops;
    send(rnd());
    drain();
    chk("t6_fresh", n_pops - p0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
